// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer pointer/valid/done bookkeeping with in-order retire.
// Optional macro QU_ROB_COMPLETE_BYPASS_EN lets a completing head tag retire in the same cycle.
`default_nettype none

module rob_ctrl #(
    parameter int ROB_DEPTH  = 16,
    localparam int ROB_ADDR_W = $clog2(ROB_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_req_i,
    output logic                  alloc_gnt_o,
    output logic [ROB_ADDR_W-1:0] tail_ptr_o,
    input  logic                  complete_en_i,
    input  logic [ROB_ADDR_W-1:0] complete_addr_i,
    input  logic                  flush_i,
    output logic                  retire_en_o,
    output logic [ROB_ADDR_W-1:0] retire_rob_addr_o,
    output logic [ROB_ADDR_W-1:0] head_ptr_o,
    output logic [ROB_ADDR_W:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    typedef logic [ROB_ADDR_W-1:0] rob_addr_t;
    typedef logic [ROB_ADDR_W:0]   rob_cnt_t;

    localparam rob_addr_t FIRST_TAG = rob_addr_t'(1);
    localparam rob_addr_t LAST_TAG  = rob_addr_t'(ROB_DEPTH - 1);
    localparam rob_cnt_t  FULL_CNT  = rob_cnt_t'(ROB_DEPTH - 1);

    rob_addr_t              head_q, head_d;
    rob_addr_t              tail_q, tail_d;
    rob_cnt_t               count_q, count_d;
    logic [ROB_DEPTH-1:0]   valid_q, valid_d;
    logic [ROB_DEPTH-1:0]   done_q, done_d;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_gnt;
    logic                   w_retire;
    logic                   w_complete_ok;

    // Tag 0 means "no tag", so pointers wrap from the last slot back to 1.
    function automatic rob_addr_t ptr_inc(input rob_addr_t p);
        return (p == LAST_TAG) ? FIRST_TAG : rob_addr_t'(p + 1'b1);
    endfunction

    assign w_full        = (count_q == FULL_CNT);
    assign w_empty       = (count_q == '0);
    assign w_gnt         = alloc_req_i & ~w_full & ~flush_i;
    assign w_complete_ok = complete_en_i & valid_q[complete_addr_i];

`ifdef QU_ROB_COMPLETE_BYPASS_EN
    assign w_retire = ~flush_i & ((~w_empty & done_q[head_ptr_o]) |
                                  (w_complete_ok & (complete_addr_i == head_q)));
`else
    assign w_retire = ~flush_i & ~w_empty & done_q[head_q];
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (flush_i) begin
            head_d  = FIRST_TAG;
            tail_d  = FIRST_TAG;
            count_d = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            if (w_complete_ok) begin
                done_d[complete_addr_i] = 1'b1;
            end
            if (w_gnt) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = ptr_inc(tail_q);
            end
            // Retire clears last so a same-cycle completion of the head has no lasting effect.
            if (w_retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = ptr_inc(head_q);
            end
            case ({w_gnt, w_retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= FIRST_TAG;
            tail_q  <= FIRST_TAG;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign alloc_gnt_o       = w_gnt;
    assign tail_ptr_o        = tail_q;
    assign retire_en_o       = w_retire;
    assign retire_rob_addr_o = head_q;
    assign head_ptr_o        = head_q;
    assign count_o           = count_q;
    assign full_o            = w_full;
    assign empty_o           = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed stimulus for rob_ctrl (ROB_DEPTH=8) checked against a queue-based model.
`default_nettype none

module tb_rob_ctrl;

    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [AW-1:0] tail_ptr;
    logic          complete_en;
    logic [AW-1:0] complete_addr;
    logic          flush;
    logic          retire_en;
    logic [AW-1:0] retire_rob_addr;
    logic [AW-1:0] head_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    rob_ctrl #(.ROB_DEPTH(D)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .alloc_req_i       (alloc_req),
        .alloc_gnt_o       (alloc_gnt),
        .tail_ptr_o        (tail_ptr),
        .complete_en_i     (complete_en),
        .complete_addr_i   (complete_addr),
        .flush_i           (flush),
        .retire_en_o       (retire_en),
        .retire_rob_addr_o (retire_rob_addr),
        .head_ptr_o        (head_ptr),
        .count_o           (count),
        .full_o            (full),
        .empty_o           (empty)
    );

    always #5 clk = ~clk;

    // Model: in-flight tags held oldest-first in a queue, done flags per tag.
    int q[$];
    bit mdone[D];
    int mhead;
    int mtail;

    function automatic bit in_flight(input int tag);
        foreach (q[i]) if (q[i] == tag) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_gnt();
        return alloc_req && (q.size() < D - 1) && !flush;
    endfunction

    function automatic bit exp_ret();
        bit r;
        r = (q.size() > 0) && mdone[q[0]] && !flush;
`ifdef QU_ROB_COMPLETE_BYPASS_EN
        if (complete_en && (q.size() > 0) && (int'(complete_addr) == q[0]) && !flush) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic int next_tag(input int t);
        return (t == D - 1) ? 1 : t + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit g, r;
        if (!rst_n) begin
            q.delete();
            foreach (mdone[i]) mdone[i] = 1'b0;
            mhead = 1;
            mtail = 1;
        end else if (flush) begin
            q.delete();
            foreach (mdone[i]) mdone[i] = 1'b0;
            mhead = 1;
            mtail = 1;
        end else begin
            g = exp_gnt();
            r = exp_ret();
            if (complete_en && in_flight(int'(complete_addr))) mdone[complete_addr] = 1'b1;
            if (r) begin
                mdone[q[0]] = 1'b0;
                void'(q.pop_front());
                mhead = next_tag(mhead);
            end
            if (g) begin
                q.push_back(mtail);
                mdone[mtail] = 1'b0;
                mtail = next_tag(mtail);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_gnt",    32'(alloc_gnt),       32'(exp_gnt()));
        chk("m_tail",   32'(tail_ptr),        32'(mtail));
        chk("m_ret",    32'(retire_en),       32'(exp_ret()));
        chk("m_raddr",  32'(retire_rob_addr), 32'(mhead));
        chk("m_head",   32'(head_ptr),        32'(mhead));
        chk("m_count",  32'(count),           32'(q.size()));
        chk("m_full",   32'(full),            32'(q.size() == D - 1));
        chk("m_empty",  32'(empty),           32'(q.size() == 0));
    end

    task automatic cyc(input bit req, input bit ce, input int ca, input bit fl);
        @(posedge clk);
        #1;
        alloc_req     = req;
        complete_en   = ce;
        complete_addr = AW'(ca);
        flush         = fl;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_req = 1'b0; complete_en = 1'b0; complete_addr = '0; flush = 1'b0;
        @(negedge clk);
        chk("rst_head", 32'(head_ptr), 1);
        chk("rst_tail", 32'(tail_ptr), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_raddr", 32'(retire_rob_addr), 1);
        chk("rst_ret", 32'(retire_en), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill to full: tags 1..7, then the 8th request is refused.
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 0, 0, 0);
            chk("fill_gnt", 32'(alloc_gnt), 1);
            chk("fill_tag", 32'(tail_ptr), 32'(i));
        end
        cyc(1, 0, 0, 0);
        chk("full_gnt", 32'(alloc_gnt), 0);
        chk("full_tail", 32'(tail_ptr), 1);
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), 7);

        // Out-of-order completion: 2 then 1, retire in order.
        cyc(0, 1, 2, 0);
        chk("ooo_ret_a", 32'(retire_en), 0);
        cyc(0, 0, 0, 0);
        chk("ooo_ret_b", 32'(retire_en), 0);
        cyc(0, 1, 1, 0);
`ifdef QU_ROB_COMPLETE_BYPASS_EN
        chk("ooo_ret1_byp", 32'(retire_en), 1);
`else
        chk("ooo_ret_c", 32'(retire_en), 0);
        cyc(0, 0, 0, 0);
        chk("ooo_ret1", 32'(retire_en), 1);
        chk("ooo_addr1", 32'(retire_rob_addr), 1);
`endif
        cyc(0, 0, 0, 0);
        chk("ooo_ret2", 32'(retire_en), 1);
        chk("ooo_addr2", 32'(retire_rob_addr), 2);
        cyc(0, 0, 0, 0);
        chk("ooo_head", 32'(head_ptr), 3);
        chk("ooo_count", 32'(count), 5);

        // Completion of tag 0 is ignored.
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("tag0_ret", 32'(retire_en), 0);
        chk("tag0_count", 32'(count), 5);

        // Refill across the wrap, then retire while full with alloc_req held.
        cyc(1, 0, 0, 0);
        chk("wrap_tag1", 32'(tail_ptr), 1);
        cyc(1, 0, 0, 0);
        chk("wrap_tag2", 32'(tail_ptr), 2);
        cyc(0, 1, 3, 0);
`ifndef QU_ROB_COMPLETE_BYPASS_EN
        chk("fullret_pre", 32'(retire_en), 0);
        cyc(1, 0, 0, 0);
        chk("fullret_ret", 32'(retire_en), 1);
        chk("fullret_gnt", 32'(alloc_gnt), 0);
        chk("fullret_cnt", 32'(count), 7);
        cyc(1, 0, 0, 0);
        chk("fullret_cnt6", 32'(count), 6);
        chk("fullret_gnt2", 32'(alloc_gnt), 1);
        chk("fullret_tag", 32'(tail_ptr), 3);
        cyc(0, 0, 0, 0);
        chk("fullret_cnt7", 32'(count), 7);
`endif

        // Flush with three in flight, head done, alloc requested.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("fl0_empty", 32'(empty), 1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 1);
        chk("fl_gnt", 32'(alloc_gnt), 0);
        chk("fl_ret", 32'(retire_en), 0);
        cyc(0, 0, 0, 0);
        chk("fl_head", 32'(head_ptr), 1);
        chk("fl_tail", 32'(tail_ptr), 1);
        chk("fl_empty", 32'(empty), 1);

        // Completion of an unallocated tag is ignored.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 5, 0);
        cyc(0, 0, 0, 0);
        chk("unalloc_ret", 32'(retire_en), 0);
        chk("unalloc_cnt", 32'(count), 2);

        // Simultaneous grant and retire holds count.
        cyc(0, 1, 1, 0);
`ifndef QU_ROB_COMPLETE_BYPASS_EN
        cyc(1, 0, 0, 0);
        chk("both_ret", 32'(retire_en), 1);
        chk("both_gnt", 32'(alloc_gnt), 1);
        cyc(0, 0, 0, 0);
        chk("both_cnt", 32'(count), 2);
        chk("both_head", 32'(head_ptr), 2);
        chk("both_tail", 32'(tail_ptr), 4);
`endif

        // Asynchronous reset between edges.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("prerst_cnt", 32'(count), 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_head", 32'(head_ptr), 1);
        chk("arst_tail", 32'(tail_ptr), 1);
        chk("arst_cnt", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_ret", 32'(retire_en), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 0, 0, 0);
        chk("post_rst_gnt", 32'(alloc_gnt), 1);
        chk("post_rst_tag", 32'(tail_ptr), 1);

        // Head completion latency.
        cyc(0, 1, 1, 0);
`ifdef QU_ROB_COMPLETE_BYPASS_EN
        chk("byp_ret", 32'(retire_en), 1);
        chk("byp_addr", 32'(retire_rob_addr), 1);
`else
        chk("lat_ret0", 32'(retire_en), 0);
        cyc(0, 0, 0, 0);
        chk("lat_ret1", 32'(retire_en), 1);
`endif

        // Mixed traffic checked by the model.
        for (int i = 0; i < 40; i++) begin
            cyc((i % 3) != 0, (i % 4) != 3, (i * 5) % D, i == 25);
        end

        cyc(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
